// File: rtl/icache_dm_pkg.sv
// Shared definitions for the direct-mapped instruction cache: data bus
// sizing, reset/bubble words and FSM state encodings.
package icache_dm_pkg;

  localparam int DATA_SIZE = 32;
  localparam logic [DATA_SIZE-1:0] DATA_BUS_RESET = '0;
  // A squashed fetch hands IF_ID an all-zero word.
  localparam logic [DATA_SIZE-1:0] ICACHE_BUBBLE = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_REFILL = 2'd1,
    S_RESP   = 2'd2
  } icache_state_t;

endpackage

// File: rtl/icache_dm_if.sv
// Fetch-side and backing-memory signals of the instruction cache.
// With ICACHE_STATS_EN defined the hit/miss counters are carried as well.
interface icache_dm_if #(parameter int DATA_W = 32);

  logic              flush;
  logic              inv_all;
  logic              req;
  logic [DATA_W-1:0] addr;
  logic [DATA_W-1:0] inst;
  logic              inst_vld;
  logic              stall;
  logic              mem_req;
  logic [DATA_W-1:0] mem_addr;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;
`ifdef ICACHE_STATS_EN
  logic [31:0]       hit_cnt;
  logic [31:0]       miss_cnt;

  modport slave (
    input  flush, inv_all, req, addr, mem_ack, mem_rdata,
    output inst, inst_vld, stall, mem_req, mem_addr, hit_cnt, miss_cnt
  );
  modport master (
    output flush, inv_all, req, addr, mem_ack, mem_rdata,
    input  inst, inst_vld, stall, mem_req, mem_addr, hit_cnt, miss_cnt
  );
`else
  modport slave (
    input  flush, inv_all, req, addr, mem_ack, mem_rdata,
    output inst, inst_vld, stall, mem_req, mem_addr
  );
  modport master (
    output flush, inv_all, req, addr, mem_ack, mem_rdata,
    input  inst, inst_vld, stall, mem_req, mem_addr
  );
`endif

endinterface

// File: rtl/icache_dm_array.sv
// Cache storage: data words, per-line tags and valid bits.
// One combinational read port, one word-write port, one tag/valid-write
// port and a single-cycle bulk invalidate.
module icache_dm_array #(
  parameter int DATA_W = 32,
  parameter int LINES  = 16,
  parameter int WORDS  = 4,
  parameter int OFF_W  = $clog2(WORDS),
  parameter int IDX_W  = $clog2(LINES),
  parameter int TAG_W  = DATA_W - 2 - OFF_W - IDX_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [IDX_W-1:0]  rd_idx,
  input  logic [OFF_W-1:0]  rd_off,
  output logic [DATA_W-1:0] rd_data,
  output logic [TAG_W-1:0]  rd_tag,
  output logic              rd_valid,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [OFF_W-1:0]  wr_off,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              tv_we,
  input  logic [IDX_W-1:0]  tv_idx,
  input  logic [TAG_W-1:0]  tv_tag,
  input  logic              inv_all
);

  logic [DATA_W-1:0] data_mem [LINES][WORDS];
  logic [TAG_W-1:0]  tag_mem  [LINES];
  logic [LINES-1:0]  valid;

  assign rd_data  = data_mem[rd_idx][rd_off];
  assign rd_tag   = tag_mem[rd_idx];
  assign rd_valid = valid[rd_idx];

  // Data and tag storage carry no reset; only the valid bits gate hits.
  always_ff @(posedge clk) begin
    if (wr_en) data_mem[wr_idx][wr_off] <= wr_data;
    if (tv_we) tag_mem[tv_idx] <= tv_tag;
  end

  // Invalidate first, then install: a line completing in the same cycle
  // as inv_all survives as valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= '0;
    end else begin
      if (inv_all) valid <= '0;
      if (tv_we)   valid[tv_idx] <= 1'b1;
    end
  end

endmodule

// File: rtl/icache_dm.sv
// Direct-mapped instruction cache with registered hit path, line refill
// over a req/ack word interface, stall generation and bulk invalidate.
// Optional: define ICACHE_STATS_EN to add saturating hit/miss counters.
module icache_dm
  import icache_dm_pkg::*;
#(
  parameter int DATA_W = DATA_SIZE,
  parameter int LINES  = 16,
  parameter int WORDS  = 4
) (
  input  logic       clk,
  input  logic       rst,
  icache_dm_if.slave bus
);

  localparam int OFF_W = $clog2(WORDS);
  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = DATA_W - 2 - OFF_W - IDX_W;

  logic [OFF_W-1:0]  addr_off;
  logic [IDX_W-1:0]  addr_idx;
  logic [TAG_W-1:0]  addr_tag;
  logic [DATA_W-1:0] line_base;
  logic              unused_addr;

  assign addr_off    = bus.addr[2 +: OFF_W];
  assign addr_idx    = bus.addr[2+OFF_W +: IDX_W];
  assign addr_tag    = bus.addr[DATA_W-1 -: TAG_W];
  assign line_base   = {bus.addr[DATA_W-1:2+OFF_W], {(OFF_W+2){1'b0}}};
  assign unused_addr = ^bus.addr[1:0];

  icache_state_t     state;
  logic [OFF_W-1:0]  beat;
  logic [OFF_W-1:0]  miss_off;
  logic [IDX_W-1:0]  miss_idx;
  logic [TAG_W-1:0]  miss_tag;
  logic [DATA_W-1:0] word_q;
  logic              flushed_q;
  logic [DATA_W-1:0] inst_q;
  logic              inst_vld_q;
  logic              mem_req_q;
  logic [DATA_W-1:0] mem_addr_q;

  logic [DATA_W-1:0] rd_data;
  logic [TAG_W-1:0]  rd_tag;
  logic              rd_valid;

  logic              lookup, hit, miss;
  logic              ack_beat, last_beat;
  logic [DATA_W-1:0] resp_word;

  // Lookup only from IDLE on an unflushed request; reads see the valid
  // bits as they stand before any same-cycle invalidate.
  assign lookup    = !rst && (state == S_IDLE) && bus.req && !bus.flush;
  assign hit       = lookup && rd_valid && (rd_tag == addr_tag);
  assign miss      = lookup && !hit;
  assign ack_beat  = (state == S_REFILL) && bus.mem_ack;
  assign last_beat = ack_beat && (beat == OFF_W'(WORDS - 1));
  // The missed word may arrive on the very last beat.
  assign resp_word = (beat == miss_off) ? bus.mem_rdata : word_q;

  icache_dm_array #(
    .DATA_W(DATA_W), .LINES(LINES), .WORDS(WORDS)
  ) u_array (
    .clk     (clk),
    .rst     (rst),
    .rd_idx  (addr_idx),
    .rd_off  (addr_off),
    .rd_data (rd_data),
    .rd_tag  (rd_tag),
    .rd_valid(rd_valid),
    .wr_en   (ack_beat),
    .wr_idx  (miss_idx),
    .wr_off  (beat),
    .wr_data (bus.mem_rdata),
    .tv_we   (last_beat),
    .tv_idx  (miss_idx),
    .tv_tag  (miss_tag),
    .inv_all (bus.inv_all)
  );

  // Main FSM: lookup, refill beats, response, with registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      beat       <= '0;
      miss_off   <= '0;
      miss_idx   <= '0;
      miss_tag   <= '0;
      word_q     <= '0;
      flushed_q  <= 1'b0;
      inst_q     <= DATA_W'(DATA_BUS_RESET);
      inst_vld_q <= 1'b0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
    end else begin
      inst_vld_q <= 1'b0;
      if (bus.flush) inst_q <= DATA_W'(ICACHE_BUBBLE);
      case (state)
        S_IDLE: begin
          if (hit) begin
            inst_q     <= rd_data;
            inst_vld_q <= 1'b1;
          end else if (miss) begin
            state      <= S_REFILL;
            beat       <= '0;
            miss_off   <= addr_off;
            miss_idx   <= addr_idx;
            miss_tag   <= addr_tag;
            flushed_q  <= 1'b0;
            mem_req_q  <= 1'b1;
            mem_addr_q <= line_base;
          end
        end
        S_REFILL: begin
          // A flush never aborts the refill; it only hides the response.
          if (bus.flush) flushed_q <= 1'b1;
          if (bus.mem_ack) begin
            if (beat == miss_off) word_q <= bus.mem_rdata;
            if (last_beat) begin
              state     <= S_RESP;
              mem_req_q <= 1'b0;
              if (!(bus.flush || flushed_q)) begin
                inst_q     <= resp_word;
                inst_vld_q <= 1'b1;
              end
            end else begin
              beat       <= beat + 1'b1;
              mem_addr_q <= mem_addr_q + DATA_W'(4);
            end
          end
        end
        S_RESP:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.inst     = inst_q;
  assign bus.inst_vld = inst_vld_q;
  assign bus.stall    = miss || (state == S_REFILL);
  assign bus.mem_req  = mem_req_q;
  assign bus.mem_addr = mem_addr_q;

`ifdef ICACHE_STATS_EN
  logic [31:0] hit_q, miss_q;

  // Saturating lookup counters, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_q  <= '0;
      miss_q <= '0;
    end else begin
      if (hit  && hit_q  != '1) hit_q  <= hit_q + 32'd1;
      if (miss && miss_q != '1) miss_q <= miss_q + 32'd1;
    end
  end

  assign bus.hit_cnt  = hit_q;
  assign bus.miss_cnt = miss_q;
`endif

endmodule

// File: tb/tb_icache_dm.sv
// Directed bench for icache_dm: backing memory returns each word's own
// address as data; expected instructions go through a scoreboard queue.
module tb_icache_dm;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  logic [31:0] exp_q[$];

  icache_dm_if #(.DATA_W(32)) bus();

  icache_dm #(.DATA_W(32), .LINES(16), .WORDS(4)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock, score any delivered instruction, answer the memory.
  task automatic step();
    logic [31:0] e;
    @(posedge clk);
    #1;
    if (bus.inst_vld === 1'b1) begin
      if (exp_q.size() == 0) chk("unexpected_vld", bus.inst_vld, 32'd0);
      else begin
        e = exp_q.pop_front();
        chk("inst", bus.inst, e);
      end
    end
    bus.mem_ack   = bus.mem_req;
    bus.mem_rdata = bus.mem_addr;
  endtask

  task automatic hit(input logic [31:0] a);
    bus.addr = a;
    bus.req  = 1'b1;
    exp_q.push_back(a);
    #1;
    chk("hit_stall", bus.stall, 32'd0);
    step();
    chk("hit_vld", bus.inst_vld, 32'd1);
    chk("hit_memreq", bus.mem_req, 32'd0);
  endtask

  // Miss + full refill; flush_beat >= 0 raises flush during that beat.
  task automatic miss(input logic [31:0] a, input int flush_beat);
    logic [31:0] base;
    base = a & ~32'hF;
    bus.addr  = a;
    bus.req   = 1'b1;
    bus.flush = 1'b0;
    if (flush_beat < 0) exp_q.push_back(a);
    #1;
    chk("miss_stall", bus.stall, 32'd1);
    chk("miss_memreq_pre", bus.mem_req, 32'd0);
    for (int b = 0; b < 4; b++) begin
      step();
      chk("refill_memreq", bus.mem_req, 32'd1);
      chk("refill_addr", bus.mem_addr, base + 32'(4 * b));
      chk("refill_stall", bus.stall, 32'd1);
      bus.flush = (b == flush_beat);
      if (b == 1) bus.addr = a ^ 32'h100;
    end
    bus.flush = 1'b0;
    step();
    chk("resp_stall", bus.stall, 32'd0);
    chk("resp_memreq", bus.mem_req, 32'd0);
    chk("resp_vld", bus.inst_vld, (flush_beat < 0) ? 32'd1 : 32'd0);
    if (flush_beat >= 0) chk("resp_bubble", bus.inst, 32'd0);
    bus.req = 1'b0;
    step();
    chk("post_resp_vld", bus.inst_vld, 32'd0);
  endtask

  initial begin
    rst           = 1'b1;
    bus.flush     = 1'b0;
    bus.inv_all   = 1'b0;
    bus.req       = 1'b0;
    bus.addr      = '0;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
    #1;
    chk("rst_inst", bus.inst, 32'd0);
    chk("rst_vld", bus.inst_vld, 32'd0);
    chk("rst_stall", bus.stall, 32'd0);
    chk("rst_memreq", bus.mem_req, 32'd0);
    chk("rst_memaddr", bus.mem_addr, 32'd0);
    step();
    step();
    rst = 1'b0;
    step();

    // Cold miss, then a back-to-back hit stream on the same line.
    miss(32'h40, -1);
    hit(32'h44);
    hit(32'h48);
    hit(32'h4C);
    bus.req = 1'b0;
    step();
    chk("idle_vld", bus.inst_vld, 32'd0);
    chk("idle_hold", bus.inst, 32'h4C);

    // Same index, different tag evicts the line.
    miss(32'h140, -1);
    miss(32'h40, -1);

    // Flush mid-refill still installs the line.
    miss(32'h80, 1);
    hit(32'h88);

    // Flushed lookup in IDLE delivers a bubble.
    bus.addr  = 32'h84;
    bus.req   = 1'b1;
    bus.flush = 1'b1;
    #1;
    chk("flush_idle_stall", bus.stall, 32'd0);
    step();
    chk("flush_idle_vld", bus.inst_vld, 32'd0);
    chk("flush_idle_inst", bus.inst, 32'd0);
    bus.flush = 1'b0;
    bus.req   = 1'b0;
    step();

    // Same-cycle lookup sees pre-clear valid state; afterwards it misses.
    bus.inv_all = 1'b1;
    hit(32'h84);
    bus.inv_all = 1'b0;
    bus.req     = 1'b0;
    step();
    miss(32'h44, -1);
    hit(32'h48);
    miss(32'h80, -1);

    // Reset in the middle of a refill after two acks.
    bus.req     = 1'b0;
    bus.inv_all = 1'b1;
    step();
    bus.inv_all = 1'b0;
    bus.addr    = 32'h40;
    bus.req     = 1'b1;
    #1;
    chk("rstmid_miss_stall", bus.stall, 32'd1);
    step();
    step();
    step();
    chk("rstmid_memreq_pre", bus.mem_req, 32'd1);
    chk("rstmid_memaddr_pre", bus.mem_addr, 32'h48);
    #2;
    rst         = 1'b1;
    bus.req     = 1'b0;
    bus.mem_ack = 1'b0;
    #1;
    chk("rstmid_memreq", bus.mem_req, 32'd0);
    chk("rstmid_stall", bus.stall, 32'd0);
    step();
    step();
    rst = 1'b0;
    step();
    miss(32'h40, -1);

    chk("sb_empty", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
